hamming_encoder_tx: RTL and testbench
=====================================

# hamming_encoder_tx

Transmit-side companion to the Hamming(7,4) detection/correction path. Accepts 4-bit data words over a valid/ready handshake and computes the 7-bit Hamming codeword. It can flip one selected codeword bit as deliberate error injection, then buffers codewords in a small FIFO for a downstream consumer such as the decoder/corrector under test. Sits between the stimulus source (switches or test sequencer) and the `dataRaw` input of the receive path.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the sent-word counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 4: data word, bits d3..d0.
- `in_valid` input 1: `data_in` and `err_pos` are valid.
- `in_ready` output 1: block can accept a word this cycle.
- `err_pos` input 3: 0 means no injection; 1–7 means invert codeword position N. Sampled only on accept.
- `out_code` output 7: codeword at FIFO head.
- `out_valid` output 1: `out_code` is valid.
- `out_ready` input 1: consumer takes `out_code` this cycle.
- `words_sent` output CNT_W: count of codewords popped.
- `inj_pending` output 1: the head entry carries an injected error.

## Operation
- Codeword position N (1..7) maps to `out_code[N-1]`. Parity bits sit at positions 1, 2 and 4.
- The codeword is laid out as `out_code = {d3, d2, d1, p4, d0, p2, p1}`.
- Parity equations: p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
- Injection XORs `out_code[err_pos-1]` when `err_pos`≠0. With a single injected bit, the receiver syndrome equals `err_pos`.
- Encoding and injection happen at accept time. Each FIFO entry stores 7 code bits plus 1 injection flag.
- Accept (push) occurs when `in_valid && in_ready`. `in_ready = !full && !rst`.
- Pop occurs when `out_valid && out_ready`. `out_valid = !empty`.
- Pop increments `words_sent`, which wraps from 2^CNT_W−1 to 0.
- The FIFO uses read and write pointers plus an occupancy count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Simultaneous push and pop when not empty and not full: occupancy is unchanged and both pointers advance.
- Full: `in_ready` = 0 and no push is possible. A pop in the same cycle frees a slot, which becomes visible next cycle. There is no combinational ready-through.
- Empty: `out_valid` = 0 and `out_ready` is ignored. A push is visible at the output next cycle. There is no bypass.
- Outputs are held stable while `out_valid && !out_ready`: `out_code` and `inj_pending` must not change.
- `err_pos` and `data_in` are don't-care when no accept occurs.

## Timing
- Reset (`rst` high at an edge): occupancy 0, pointers 0, `words_sent` 0, `out_valid` 0, `out_code` 0, `inj_pending` 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-operation discards all buffered entries. No pop is counted in the reset cycle.
- Latency: a word accepted at edge k appears with `out_valid` = 1 after edge k, i.e. one cycle.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- `out_code` on an empty FIFO is 0; it must not show stale memory.
- All outputs except `in_ready` are registered or derived from registered state only.

## Test plan
- **Reset:** assert `rst` 2 cycles with `in_valid` = 1. Required: no accepts, `out_valid` = 0, `words_sent` = 0, `in_ready` = 1 one cycle after release.
- **Encode:** `data_in` = 4'b1011, `err_pos` = 0, `out_ready` = 1. Required: `out_code` = 7'b1010101 one cycle later, `inj_pending` = 0, `words_sent` = 1 after the pop. Also 4'b0000 → 7'b0000000 and 4'b1111 → 7'b1111111.
- **Injection:** `data_in` = 4'b1011 with `err_pos` = 3 → `out_code` = 7'b1010001, `inj_pending` = 1. Sweep `err_pos` 1–7; each output must differ from 7'b1010101 only in bit `err_pos`-1.
- **Backpressure:** `out_ready` = 0, push 3 words. Required: 2 accepted, `in_ready` = 0 after the second, head stable. Then raise `out_ready`: pops come out in order and `in_ready` returns the cycle after the first pop.
- **Streaming:** random push/pop for 1000 cycles against a scoreboard. Required: no loss, no duplication, order preserved.
- **Counter wrap:** at `CNT_W` = 8, 256 pops → `words_sent` = 0.
- **Mid-stream reset:** reset with 2 entries held. Required: empty next cycle and no stale entries emitted.

Source files
------------

// File: rtl/hamming_encoder_tx_if.sv
// Handshake bundle between a word source, the Hamming(7,4) encoder/FIFO and its consumer.
interface hamming_encoder_tx_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       data_in;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       err_pos;
  logic [6:0]       out_code;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] words_sent;
  logic             inj_pending;

  modport master (
    output data_in, in_valid, err_pos, out_ready,
    input  in_ready, out_code, out_valid, words_sent, inj_pending
  );

  modport slave (
    input  data_in, in_valid, err_pos, out_ready,
    output in_ready, out_code, out_valid, words_sent, inj_pending
  );
endinterface

// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with optional single-bit error injection, buffered in a small FIFO.
module hamming_encoder_tx #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  hamming_encoder_tx_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned ENT_W = CODE_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] sent_q, sent_d;

  logic              full, empty, push, pop;
  logic              p1, p2, p4;
  logic [CODE_W-1:0] code_enc, inj_mask;
  logic [ENT_W-1:0]  entry;

  // Encode and inject at accept time; the stored flag marks injected entries.
  always_comb begin
    p1       = bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3];
    p2       = bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3];
    p4       = bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3];
    code_enc = {bus.data_in[3], bus.data_in[2], bus.data_in[1], p4, bus.data_in[0], p2, p1};
    inj_mask = '0;
    if (bus.err_pos != 3'd0) begin
      inj_mask[bus.err_pos - 3'd1] = 1'b1;
    end
    entry = {(bus.err_pos != 3'd0), code_enc ^ inj_mask};
  end

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign push  = bus.in_valid && !full && !rst;
  assign pop   = !empty && bus.out_ready;

  assign bus.in_ready    = !full && !rst;
  assign bus.out_valid   = !empty;
  assign bus.out_code    = empty ? '0 : mem_q[rd_ptr_q][CODE_W-1:0];
  assign bus.inj_pending = empty ? 1'b0 : mem_q[rd_ptr_q][ENT_W-1];
  assign bus.words_sent  = sent_q;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    sent_d   = sent_q;

    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sent_d   = sent_q + CNT_W'(1);
    end
    // Occupancy holds when a push and a pop coincide.
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sent_q   <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sent_q   <= sent_d;
    end
  end
endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Randomised and directed bench for hamming_encoder_tx against a queue-based Hamming model.
module tb_hamming_encoder_tx;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst;
  logic chk_en;
  int   vectors;
  int   miscompares;

  // Model entry: {err_pos[2:0], inj flag, code[6:0]}
  logic [10:0]      mq[$];
  logic [CNT_W-1:0] m_sent;

  hamming_encoder_tx_if #(.CNT_W(CNT_W)) bus ();

  hamming_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Classic Hamming placement: data fills non-power-of-two positions, parity at 2^i
  // covers every position whose index has bit i set.
  function automatic logic [7:0] model_word(input logic [3:0] d, input int e);
    logic [7:0] cw;
    int k;
    logic par;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 7; pos++) begin
        if (((pos >> i) & 1) == 1 && pos != (1 << i)) par = par ^ cw[pos];
      end
      cw[1 << i] = par;
    end
    if (e != 0) cw[e] = ~cw[e];
    return {(e != 0), cw[7:1]};
  endfunction

  function automatic int syndrome(input logic [6:0] c);
    int s;
    s = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if (c[pos-1]) s = s ^ pos;
    end
    return s;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference update on each active edge.
  always @(posedge clk) begin
    logic do_pop, do_push;
    if (rst) begin
      mq.delete();
      m_sent = '0;
    end else begin
      do_pop  = (mq.size() > 0) && bus.out_ready;
      do_push = bus.in_valid && (mq.size() < int'(DEPTH));
      if (do_pop) begin
        void'(mq.pop_front());
        m_sent = m_sent + 8'd1;
      end
      if (do_push) mq.push_back({bus.err_pos, model_word(bus.data_in, int'(bus.err_pos))});
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [10:0] head;
    logic        ev;
    if (chk_en) begin
      ev   = (mq.size() > 0);
      head = ev ? mq[0] : 11'd0;
      cmp("out_valid",   32'(bus.out_valid),   32'(ev));
      cmp("out_code",    32'(bus.out_code),    32'(head[6:0]));
      cmp("inj_pending", 32'(bus.inj_pending), 32'(head[7]));
      cmp("words_sent",  32'(bus.words_sent),  32'(m_sent));
      cmp("in_ready",    32'(bus.in_ready),    32'((mq.size() < int'(DEPTH)) && !rst));
      if (ev && bus.out_valid === 1'b1) begin
        cmp("syndrome", 32'(syndrome(bus.out_code)), 32'(head[10:8]));
      end
    end
  end

  task automatic tick(input logic r, input logic v, input logic [3:0] d,
                      input logic [2:0] e, input logic rdy);
    @(negedge clk);
    #1;
    rst           = r;
    bus.in_valid  = v;
    bus.data_in   = d;
    bus.err_pos   = e;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    chk_en        = 1'b0;
    m_sent        = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = 4'hA;
    bus.err_pos   = 3'd0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    tick(1'b1, 1'b1, 4'hA, 3'd0, 1'b0);
    chk_en = 1'b1;
    tick(1'b1, 1'b1, 4'h5, 3'd0, 1'b1);
    cmp("rst_out_valid",  32'(bus.out_valid),  32'd0);
    cmp("rst_words_sent", 32'(bus.words_sent), 32'd0);
    cmp("rst_in_ready",   32'(bus.in_ready),   32'd0);
    cmp("rst_out_code",   32'(bus.out_code),   32'd0);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b0);
    cmp("rel_in_ready",  32'(bus.in_ready),  32'd1);
    cmp("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // Plain encodes
    tick(1'b0, 1'b1, 4'b1011, 3'd0, 1'b0);
    cmp("enc_1011",     32'(bus.out_code),    32'(7'b1010101));
    cmp("enc_1011_inj", 32'(bus.inj_pending), 32'd0);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("enc_sent1", 32'(bus.words_sent), 32'd1);
    tick(1'b0, 1'b1, 4'b0000, 3'd0, 1'b0);
    cmp("enc_0000", 32'(bus.out_code), 32'(7'b0000000));
    cmp("enc_0000_valid", 32'(bus.out_valid), 32'd1);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    tick(1'b0, 1'b1, 4'b1111, 3'd0, 1'b0);
    cmp("enc_1111", 32'(bus.out_code), 32'(7'b1111111));
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("enc_sent3", 32'(bus.words_sent), 32'd3);

    // Injection and err_pos sweep
    tick(1'b0, 1'b1, 4'b1011, 3'd3, 1'b0);
    cmp("inj_pos3",      32'(bus.out_code),    32'(7'b1010001));
    cmp("inj_pos3_flag", 32'(bus.inj_pending), 32'd1);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      logic [6:0] base;
      base = 7'b1010101;
      tick(1'b0, 1'b1, 4'b1011, 3'(e), 1'b0);
      cmp("inj_sweep_diff", 32'(bus.out_code ^ base), 32'(7'd1 << (e - 1)));
      cmp("inj_sweep_flag", 32'(bus.inj_pending), 32'd1);
      tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    end

    // Backpressure: third push refused, head stable, ready returns after first pop
    tick(1'b0, 1'b1, 4'h1, 3'd0, 1'b0);
    tick(1'b0, 1'b1, 4'h2, 3'd0, 1'b0);
    cmp("bp_full_ready", 32'(bus.in_ready), 32'd0);
    cmp("bp_head_a",     32'(bus.out_code), 32'(7'b0000111));
    tick(1'b0, 1'b1, 4'h3, 3'd0, 1'b0);
    cmp("bp_head_hold",  32'(bus.out_code), 32'(7'b0000111));
    cmp("bp_still_full", 32'(bus.in_ready), 32'd0);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("bp_ready_back", 32'(bus.in_ready), 32'd1);
    cmp("bp_head_b",     32'(bus.out_code), 32'(7'b0011001));
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("bp_empty_valid", 32'(bus.out_valid), 32'd0);
    cmp("bp_empty_code",  32'(bus.out_code),  32'd0);

    // Random streaming against the model
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0,
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);

    // Counter wrap after 256 pops
    tick(1'b1, 1'b0, 4'h0, 3'd0, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b0);
    for (int i = 0; i < 256; i++) tick(1'b0, 1'b1, 4'($urandom), 3'd0, 1'b1);
    cmp("wrap_255", 32'(bus.words_sent), 32'd255);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("wrap_0", 32'(bus.words_sent), 32'd0);

    // Mid-stream reset with two entries held
    tick(1'b0, 1'b1, 4'h5, 3'd0, 1'b0);
    tick(1'b0, 1'b1, 4'h6, 3'd0, 1'b0);
    cmp("mid_held", 32'(bus.out_valid), 32'd1);
    tick(1'b1, 1'b1, 4'h7, 3'd2, 1'b1);
    cmp("mid_valid", 32'(bus.out_valid),  32'd0);
    cmp("mid_sent",  32'(bus.words_sent), 32'd0);
    cmp("mid_code",  32'(bus.out_code),   32'd0);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("mid_after_valid", 32'(bus.out_valid), 32'd0);
    cmp("mid_after_ready", 32'(bus.in_ready),  32'd1);
    tick(1'b0, 1'b0, 4'h0, 3'd0, 1'b1);
    cmp("mid_no_stale", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
